// File: rtl/lstm_seq_ctrl.sv
// Sequencer for a 4-unit LSTM cell: steps the MAC datapath through 16 gate rows per timestep,
// then the cell/hidden update, then a handshaked ht output, for seq_len timesteps.
module lstm_seq_ctrl #(
   parameter int unsigned UNITS = 4,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] seq_len,
   output logic             busy,
   output logic             done,
   input  logic             x_valid,
   output logic             x_ready,
   output logic             x_load,
   output logic             state_clr,
   output logic             mac_clr,
   output logic             mac_en,
   output logic             mac_sel,
   output logic [3:0]       w_addr,
   output logic [5:0]       u_addr,
   output logic [1:0]       h_idx,
   output logic             pre_we,
   output logic [3:0]       gate_idx,
   output logic             upd_en,
   output logic [1:0]       unit_idx,
   output logic             ht_valid,
   input  logic             ht_ready
);

   localparam logic [3:0] LastRow  = 4'(4 * UNITS - 1);
   localparam logic [1:0] LastUnit = 2'(UNITS - 1);
   localparam logic [2:0] LastSub  = 3'd5;

   typedef enum logic [2:0] {StIdle, StWaitX, StGate, StUpdate, StOut} state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   steps_q, steps_d;
   logic [3:0]         row_q, row_d;
   logic [2:0]         sub_q, sub_d;
   logic [1:0]         unit_q, unit_d;
   logic               first_q, first_d;
   logic               done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         steps_q <= '0;
         row_q   <= '0;
         sub_q   <= '0;
         unit_q  <= '0;
         first_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         steps_q <= steps_d;
         row_q   <= row_d;
         sub_q   <= sub_d;
         unit_q  <= unit_d;
         first_q <= first_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      steps_d = steps_q;
      row_d   = row_q;
      sub_d   = sub_q;
      unit_d  = unit_q;
      first_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (seq_len != '0) begin
                  state_d = StWaitX;
                  steps_d = seq_len;
                  first_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StWaitX: begin
            if (x_valid) begin
               state_d = StGate;
               row_d   = '0;
               sub_d   = '0;
            end
         end
         StGate: begin
            if (sub_q == LastSub) begin
               sub_d = '0;
               if (row_q == LastRow) begin
                  state_d = StUpdate;
                  row_d   = '0;
                  unit_d  = '0;
               end else begin
                  row_d = row_q + 4'd1;
               end
            end else begin
               sub_d = sub_q + 3'd1;
            end
         end
         StUpdate: begin
            if (unit_q == LastUnit) begin
               state_d = StOut;
               unit_d  = '0;
            end else begin
               unit_d = unit_q + 2'd1;
            end
         end
         StOut: begin
            if (ht_ready) begin
               steps_d = steps_q - LEN_W'(1);
               // Last step: the counter lands on zero and never wraps.
               if (steps_q == LEN_W'(1)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StWaitX;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = done_q;
      x_ready   = (state_q == StWaitX);
      state_clr = first_q;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      mac_sel   = 1'b0;
      w_addr    = '0;
      u_addr    = '0;
      h_idx     = '0;
      pre_we    = 1'b0;
      gate_idx  = '0;
      upd_en    = 1'b0;
      unit_idx  = '0;
      ht_valid  = (state_q == StOut);
      if (state_q == StGate) begin
         if (sub_q == 3'd0) begin
            mac_clr = 1'b1;
            mac_en  = 1'b1;
            w_addr  = row_q;
         end else if (sub_q == LastSub) begin
            pre_we   = 1'b1;
            gate_idx = row_q;
         end else begin
            // Recurrent term: u_lstm column block (s-1) holds weights for ht_prev[s-1].
            mac_en  = 1'b1;
            mac_sel = 1'b1;
            h_idx   = 2'(sub_q - 3'd1);
            u_addr  = {2'(sub_q - 3'd1), row_q};
         end
      end
      if (state_q == StUpdate) begin
         upd_en   = 1'b1;
         unit_idx = unit_q;
      end
   end

   assign x_load = x_valid & x_ready;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed testbench for lstm_seq_ctrl: cycle-exact single step, stalls, zero length,
// asynchronous reset mid-gate, ignored start, and maximum sequence length.
module tb_lstm_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] seq_len = '0;
   logic       x_valid = 1'b0;
   logic       ht_ready = 1'b0;
   logic       busy, done, x_ready, x_load, state_clr, mac_clr, mac_en, mac_sel;
   logic [3:0] w_addr, gate_idx;
   logic [5:0] u_addr;
   logic [1:0] h_idx, unit_idx;
   logic       pre_we, upd_en, ht_valid;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lstm_seq_ctrl #(.UNITS(4), .LEN_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .seq_len   (seq_len),
      .busy      (busy),
      .done      (done),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .x_load    (x_load),
      .state_clr (state_clr),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .mac_sel   (mac_sel),
      .w_addr    (w_addr),
      .u_addr    (u_addr),
      .h_idx     (h_idx),
      .pre_we    (pre_we),
      .gate_idx  (gate_idx),
      .upd_en    (upd_en),
      .unit_idx  (unit_idx),
      .ht_valid  (ht_valid),
      .ht_ready  (ht_ready)
   );

   logic [28:0] obs;
   assign obs = {busy, done, x_ready, x_load, state_clr, mac_clr, mac_en, mac_sel, pre_we,
                 upd_en, ht_valid, w_addr, u_addr, h_idx, gate_idx, unit_idx};

   // Expected outputs for a seq_len=1 run with x_valid=ht_ready=1 and start driven in cycle 0.
   function automatic logic [28:0] exp_single(input int c);
      logic b, d, xr, xl, sc, mc, me, ms, pw, ue, hv;
      logic [3:0] wa, gi;
      logic [5:0] ua;
      logic [1:0] hi, ui;
      int g, s;
      b = 0; d = 0; xr = 0; xl = 0; sc = 0; mc = 0; me = 0; ms = 0; pw = 0; ue = 0; hv = 0;
      wa = 0; gi = 0; ua = 0; hi = 0; ui = 0;
      if (c == 1) begin
         b = 1; xr = 1; xl = 1; sc = 1;
      end else if (c >= 2 && c <= 97) begin
         b = 1;
         g = (c - 2) / 6;
         s = (c - 2) % 6;
         if (s == 0) begin
            mc = 1; me = 1; wa = 4'(g);
         end else if (s == 5) begin
            pw = 1; gi = 4'(g);
         end else begin
            me = 1; ms = 1; hi = 2'(s - 1); ua = 6'(16 * (s - 1) + g);
         end
      end else if (c >= 98 && c <= 101) begin
         b = 1; ue = 1; ui = 2'(c - 98);
      end else if (c == 102) begin
         b = 1; hv = 1;
      end else if (c == 103) begin
         d = 1;
      end
      return {b, d, xr, xl, sc, mc, me, ms, pw, ue, hv, wa, ua, hi, gi, ui};
   endfunction

   task automatic run_seq(input logic [7:0] len, input int pulse_at, input int limit,
                          output int hs, output int dcyc, output int npre);
      hs = 0; dcyc = -1; npre = 0;
      x_valid = 1; ht_ready = 1;
      @(negedge clk);
      start = 1; seq_len = len;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         start = (c == pulse_at);
         if (c == pulse_at) seq_len = 8'd5;
         #1;
         if (ht_valid && ht_ready) hs++;
         if (pre_we) npre++;
         if (done) begin
            dcyc = c;
            break;
         end
      end
      start = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; start = 1; seq_len = 8'd3; x_valid = 1; ht_ready = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL reset_hold: got %h expected %h", obs, 29'h0);
      end
      start = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== '0) begin
            errors++; $display("FAIL reset_release %0d: got %h expected %h", i, obs, 29'h0);
         end
      end
   endtask

   task automatic test_single_step(input string name);
      int npre;
      npre = 0;
      x_valid = 1; ht_ready = 1; start = 0; seq_len = 8'd1;
      @(negedge clk);
      for (int c = 0; c <= 104; c++) begin
         checks++;
         if (obs !== exp_single(c)) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp_single(c));
         end
         if (pre_we) npre++;
         if (c == 0) start = 1;
         if (c == 1) begin
            start = 0; seq_len = 8'd9;
         end
         @(negedge clk);
      end
      checks++;
      if (npre !== 16) begin
         errors++; $display("FAIL %s pre_we_count: got %0d expected 16", name, npre);
      end
   endtask

   task automatic test_zero_len();
      @(negedge clk);
      start = 1; seq_len = 8'd0;
      @(negedge clk);
      start = 0;
      checks++;
      if (obs !== (29'd1 << 27)) begin
         errors++; $display("FAIL zero_len_done: got %h expected %h", obs, 29'd1 << 27);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== '0) begin
            errors++; $display("FAIL zero_len_quiet %0d: got %h expected %h", i, obs, 29'h0);
         end
      end
   endtask

   task automatic test_stall();
      int hs, xl, sc, dn, xw, hw, dfirst;
      hs = 0; xl = 0; sc = 0; dn = 0; xw = 0; hw = 0; dfirst = -1;
      x_valid = 1; ht_ready = 1;
      @(negedge clk);
      start = 1; seq_len = 8'd3;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 0; seq_len = 8'd1;
         end
         if (hs == 0 && hw > 0 && hw < 5) begin
            checks++;
            if (ht_valid !== 1'b1) begin
               errors++; $display("FAIL stall_ht_valid cycle %0d: got %b expected 1", c, ht_valid);
            end
         end
         if (hs == 0 && ht_valid && hw < 5) begin
            ht_ready = 0; hw++;
         end else begin
            ht_ready = 1;
         end
         if (hs == 1 && xw > 0 && xw < 10) begin
            checks++;
            if (x_ready !== 1'b1) begin
               errors++; $display("FAIL stall_x_ready cycle %0d: got %b expected 1", c, x_ready);
            end
         end
         if (hs == 1 && x_ready && xw < 10) begin
            x_valid = 0; xw++;
         end else begin
            x_valid = 1;
         end
         #1;
         if (ht_valid && ht_ready) hs++;
         if (x_load) xl++;
         if (state_clr) sc++;
         if (done) begin
            dn++;
            if (dfirst < 0) dfirst = c;
         end
         if (dfirst >= 0 && c > dfirst + 5) break;
      end
      checks++;
      if (dfirst !== 322) begin
         errors++; $display("FAIL stall_done_cycle: got %0d expected 322", dfirst);
      end
      checks++;
      if (hs !== 3) begin
         errors++; $display("FAIL stall_handshakes: got %0d expected 3", hs);
      end
      checks++;
      if (xl !== 3) begin
         errors++; $display("FAIL stall_x_loads: got %0d expected 3", xl);
      end
      checks++;
      if (sc !== 1) begin
         errors++; $display("FAIL stall_state_clr: got %0d expected 1", sc);
      end
      checks++;
      if (dn !== 1) begin
         errors++; $display("FAIL stall_done_pulses: got %0d expected 1", dn);
      end
   endtask

   task automatic test_start_in_update();
      int hs, dcyc, npre;
      run_seq(8'd2, 99, 400, hs, dcyc, npre);
      checks++;
      if (dcyc !== 205) begin
         errors++; $display("FAIL upd_start_done_cycle: got %0d expected 205", dcyc);
      end
      checks++;
      if (hs !== 2) begin
         errors++; $display("FAIL upd_start_handshakes: got %0d expected 2", hs);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL upd_start_busy_at_done: got %b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      x_valid = 1; ht_ready = 1;
      @(negedge clk);
      start = 1; seq_len = 8'd1;
      for (int c = 1; c <= 47; c++) begin
         @(negedge clk);
         start = 0;
      end
      checks++;
      if (obs !== exp_single(47)) begin
         errors++; $display("FAIL mid_row7_s3: got %h expected %h", obs, exp_single(47));
      end
      rst_n = 0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL mid_async_reset: got %h expected %h", obs, 29'h0);
      end
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL mid_reset_hold: got %h expected %h", obs, 29'h0);
      end
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== '0) begin
            errors++; $display("FAIL mid_no_resume %0d: got %h expected %h", i, obs, 29'h0);
         end
      end
      test_single_step("after_reset");
   endtask

   task automatic test_max_len();
      int hs, dcyc, npre;
      run_seq(8'd255, -1, 30000, hs, dcyc, npre);
      checks++;
      if (dcyc !== 26011) begin
         errors++; $display("FAIL max_len_done_cycle: got %0d expected 26011", dcyc);
      end
      checks++;
      if (hs !== 255) begin
         errors++; $display("FAIL max_len_handshakes: got %0d expected 255", hs);
      end
      checks++;
      if (npre !== 4080) begin
         errors++; $display("FAIL max_len_pre_we: got %0d expected 4080", npre);
      end
   endtask

   initial begin
      test_reset();
      test_single_step("single_step");
      test_zero_len();
      test_stall();
      test_start_in_update();
      test_reset_mid();
      test_max_len();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lstm_seq_ctrl.md
LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 Parameter: UNITS, 4, number of hidden units (fixed at 4 in this revision; 16 gate rows = 4 gates x UNITS).
REQ-002 Parameter: LEN_W, 8, width of the sequence-length field.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  begin a sequence; sampled only in IDLE.
REQ-006 seq_len  in  LEN_W  number of timesteps; sampled with start.
REQ-007 busy  out  1  high whenever state != IDLE.
REQ-008 done  out  1  one-cycle pulse at sequence completion.
REQ-009 x_valid / x_ready  in / out  1 / 1  xt input handshake; x_load  out  1  = x_valid & x_ready, datapath captures xt.
REQ-010 state_clr  out  1  datapath zeroes ht_prev/ct_prev.
REQ-011 mac_clr, mac_en, mac_sel  out  1 each  accumulator clear, enable, operand select (0 = xt*w, 1 = h*u).
REQ-012 w_addr  out  4  w_lstm index; u_addr  out  6  u_lstm index; h_idx  out  2  ht_prev index.
REQ-013 pre_we  out  1  write pre-activation (accumulator + b_lstm) to row gate_idx; gate_idx  out  4.
REQ-014 upd_en  out  1  compute ct/ht for unit unit_idx; unit_idx  out  2.
REQ-015 ht_valid / ht_ready  out / in  1 / 1  per-step ht output handshake.

Function
REQ-016 States: IDLE, WAIT_X, GATE, UPDATE, OUT; encoding is free.
REQ-017 IDLE: start=1, seq_len>0 -> WAIT_X; step counter loaded with seq_len.
REQ-018 IDLE: start=1, seq_len=0 -> stay IDLE; done=1 next cycle; no other output asserts.
REQ-019 state_clr=1 only in the first WAIT_X cycle after leaving IDLE.
REQ-020 WAIT_X: x_ready=1; x_valid=1 -> GATE next cycle; otherwise hold indefinitely.
REQ-021 GATE: 16 rows g=0..15 in order, 6 cycles each (sub-counter s=0..5), 96 cycles total.
REQ-022 s=0: mac_clr=1, mac_en=1, mac_sel=0, w_addr=g.
REQ-023 s=1..4: mac_en=1, mac_sel=1, h_idx=s-1, u_addr=16*(s-1)+g.
REQ-024 s=5: pre_we=1, gate_idx=g; after g=15,s=5 -> UPDATE.
REQ-025 Row order: 0-3 input, 4-7 forget, 8-11 candidate, 12-15 output gate.
REQ-026 UPDATE: 4 cycles, upd_en=1, unit_idx=0,1,2,3; then OUT.
REQ-027 OUT: ht_valid=1 held until ht_ready=1; on handshake, decrement step counter; remaining>0 -> WAIT_X, else -> IDLE with done=1 in that first IDLE cycle.
REQ-028 Outputs other than x_load are decoded from registered state/counters only; x_load is the only combinational input-to-output path.
REQ-029 All strobes not named for the current state/sub-cycle are 0; address/index outputs are 0 when not in use.
REQ-030 start while busy is ignored; seq_len changes while busy have no effect.
REQ-031 Per step with x_valid and ht_ready held high: 102 cycles (1 WAIT_X + 96 GATE + 4 UPDATE + 1 OUT).
REQ-032 seq_len = 2^LEN_W-1 runs to completion; the step counter does not wrap.

Reset
REQ-033 rst_n=0 at any time, including mid-GATE: state -> IDLE immediately, all counters 0, all outputs 0 (busy, done, x_ready, ht_valid, all strobes, all indices).
REQ-034 After rst_n release, no activity until a new start; an interrupted sequence is not resumed.

Verification
REQ-035 seq_len=1, x_valid=ht_ready=1, start at cycle 0 -> state_clr and x_load at cycle 1; GATE cycles 2-97; upd_en cycles 98-101; ht_valid at 102; done=1, busy=0 at 103.
REQ-036 GATE address check: row g=5 -> s=0 w_addr=5; s=1..4 u_addr=5,21,37,53 with h_idx 0..3; s=5 pre_we=1, gate_idx=5; exactly 16 pre_we pulses per step.
REQ-037 seq_len=3, x_valid withheld 10 cycles before step 2, ht_ready withheld 5 cycles at step 1 -> x_ready and ht_valid held stable; 3 ht handshakes; state_clr only once; single done.
REQ-038 seq_len=0 with start -> done pulse next cycle; busy, state_clr, x_ready never assert.
REQ-039 rst_n low at GATE row 7, s=3 -> all outputs 0 asynchronously; after release, new start with seq_len=1 completes in 103 cycles.
REQ-040 start pulsed during UPDATE -> ignored; sequence count and done timing unchanged.
